// File: rtl/gpu_bus_pkg.sv
// Shared register map, target codes and FIFO entry layout
// for the CPU-facing VRAM write path of the GPU.
package gpu_bus_pkg;

   localparam logic [2:0] REG_CTRL   = 3'd0;
   localparam logic [2:0] REG_PTR_LO = 3'd1;
   localparam logic [2:0] REG_PTR_HI = 3'd2;
   localparam logic [2:0] REG_DATA   = 3'd3;
   localparam logic [2:0] REG_STEP   = 3'd4;

   typedef enum logic [1:0] {
      TGT_TILE  = 2'd0,
      TGT_ATTR  = 2'd1,
      TGT_COLOR = 2'd2,
      TGT_NONE  = 2'd3
   } target_e;

   localparam logic [7:0] CTRL_RST = 8'h04;
   localparam logic [7:0] STEP_RST = 8'h01;

   localparam int TILE_AW  = 11;
   localparam int ATTR_AW  = 12;
   localparam int COLOR_AW = 4;

   typedef struct packed {
      target_e     target;
      logic [11:0] addr;
      logic [7:0]  data;
   } fifo_entry_t;

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO of pending memory writes; DEPTH must be
// a power of two. Push when full and pop when empty are ignored.
module vram_write_fifo
   import gpu_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        push_i,
   input  fifo_entry_t din_i,
   input  logic        pop_i,
   output fifo_entry_t dout_o,
   output logic        full_o,
   output logic        empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/vram_write_port.sv
// CPU register port feeding tile/attribute/color memory writes.
// Define VRAM_BLANK_WRITE_EN to drain writes only during vga_blank.
module vram_write_port
   import gpu_bus_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        CLK100MHz,
   input  logic        rst,
   input  logic [7:0]  data,
   input  logic [2:0]  addr,
   input  logic        rw,
   input  logic        cs_clock,
   input  logic        vga_blank,
   output logic        tile_memory_write_enable,
   output logic [10:0] tile_memory_write_addr,
   output logic [7:0]  tile_memory_write_data,
   output logic        attribute_memory_write_enable,
   output logic [11:0] attribute_memory_write_addr,
   output logic [7:0]  attribute_memory_write_data,
   output logic        color_memory_write_enable,
   output logic [3:0]  color_memory_write_addr,
   output logic [7:0]  color_memory_write_data,
   output logic        busy,
   output logic        overflow
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   wr;

   target_e     tgt_q, tgt_d;
   logic        inc_q, inc_d;
   logic [11:0] ptr_q, ptr_d;
   logic [7:0]  step_q, step_d;
   logic        ovf_q, ovf_d;
   logic [2:0]  en_q, en_d;
   logic [11:0] oaddr_q;
   logic [7:0]  odata_q;

   logic        push;
   logic        pop;
   logic        drain;
   logic        full;
   logic        empty;
   fifo_entry_t din;
   fifo_entry_t dout;

   // Falling edge of the synchronized strobe commits the access
   assign wr = prev_q & ~sync_q[SYNC_STAGES-1] & ~rw;

`ifdef VRAM_BLANK_WRITE_EN
   assign drain = vga_blank;
`else
   logic unused_blank;
   assign unused_blank = vga_blank;
   assign drain = 1'b1;
`endif

   assign pop = ~empty & drain;
   assign din = '{target: tgt_q, addr: ptr_q, data: data};

   always_comb begin
      tgt_d  = tgt_q;
      inc_d  = inc_q;
      ptr_d  = ptr_q;
      step_d = step_q;
      ovf_d  = ovf_q;
      push   = 1'b0;
      if (wr) begin
         unique case (1'b1)
            (addr == REG_CTRL): begin
               tgt_d = target_e'(data[1:0]);
               inc_d = data[2];
               if (data[3]) ovf_d = 1'b0;
            end
            (addr == REG_PTR_LO): ptr_d[7:0]  = data;
            (addr == REG_PTR_HI): ptr_d[11:8] = data[3:0];
            (addr == REG_DATA): begin
               if (tgt_q != TGT_NONE) begin
                  push = ~full;
                  if (full) ovf_d = 1'b1;
               end
               if (inc_q) ptr_d = ptr_q + {4'h0, step_q};
            end
            (addr == REG_STEP): step_d = data;
            default: ;
         endcase
      end
   end

   always_comb begin
      en_d = 3'b000;
      if (pop) begin
         unique case (1'b1)
            (dout.target == TGT_TILE):  en_d = 3'b001;
            (dout.target == TGT_ATTR):  en_d = 3'b010;
            (dout.target == TGT_COLOR): en_d = 3'b100;
            default:                    en_d = 3'b000;
         endcase
      end
   end

   always_ff @(posedge CLK100MHz or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         tgt_q   <= target_e'(CTRL_RST[1:0]);
         inc_q   <= CTRL_RST[2];
         ptr_q   <= '0;
         step_q  <= STEP_RST;
         ovf_q   <= 1'b0;
         en_q    <= '0;
         oaddr_q <= '0;
         odata_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], cs_clock};
         prev_q <= sync_q[SYNC_STAGES-1];
         tgt_q  <= tgt_d;
         inc_q  <= inc_d;
         ptr_q  <= ptr_d;
         step_q <= step_d;
         ovf_q  <= ovf_d;
         en_q   <= en_d;
         if (pop) begin
            oaddr_q <= dout.addr;
            odata_q <= dout.data;
         end
      end
   end

   vram_write_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLK100MHz),
      .rst_ni  (rst),
      .push_i  (push),
      .din_i   (din),
      .pop_i   (pop),
      .dout_o  (dout),
      .full_o  (full),
      .empty_o (empty)
   );

   assign tile_memory_write_enable      = en_q[0];
   assign attribute_memory_write_enable = en_q[1];
   assign color_memory_write_enable     = en_q[2];
   assign tile_memory_write_addr        = oaddr_q[TILE_AW-1:0];
   assign attribute_memory_write_addr   = oaddr_q[ATTR_AW-1:0];
   assign color_memory_write_addr       = oaddr_q[COLOR_AW-1:0];
   assign tile_memory_write_data        = odata_q;
   assign attribute_memory_write_data   = odata_q;
   assign color_memory_write_data       = odata_q;
   assign busy                          = ~empty;
   assign overflow                      = ovf_q;

endmodule

// File: tb/tb_vram_write_port.sv
// Randomized bench for vram_write_port against a register-level
// model; the VRAM_BLANK_WRITE_EN build adds stall/overflow tests.
module tb_vram_write_port;

   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  data = '0;
   logic [2:0]  addr = '0;
   logic        rw = 1'b1;
   logic        cs_clock = 1'b0;
   logic        vga_blank = 1'b1;
   logic        t_en, a_en, c_en;
   logic [10:0] t_addr;
   logic [11:0] a_addr;
   logic [3:0]  c_addr;
   logic [7:0]  t_data, a_data, c_data;
   logic        busy, overflow;

   vram_write_port #(
      .FIFO_DEPTH  (DEPTH),
      .SYNC_STAGES (SYNC)
   ) dut (
      .CLK100MHz                     (clk),
      .rst                           (rst),
      .data                          (data),
      .addr                          (addr),
      .rw                            (rw),
      .cs_clock                      (cs_clock),
      .vga_blank                     (vga_blank),
      .tile_memory_write_enable      (t_en),
      .tile_memory_write_addr        (t_addr),
      .tile_memory_write_data        (t_data),
      .attribute_memory_write_enable (a_en),
      .attribute_memory_write_addr   (a_addr),
      .attribute_memory_write_data   (a_data),
      .color_memory_write_enable     (c_en),
      .color_memory_write_addr       (c_addr),
      .color_memory_write_data       (c_data),
      .busy                          (busy),
      .overflow                      (overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_en = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int t;
      int a;
      int d;
   } ent_t;

   ent_t q[$];
   int   m_tgt, m_inc, m_ptr, m_step, m_ovf;

   task automatic model_reset();
      m_tgt = 0; m_inc = 1; m_ptr = 0; m_step = 1; m_ovf = 0;
      q.delete();
   endtask

   task automatic model_apply(input int a, input int d);
      ent_t e;
      case (a)
         0: begin
            m_tgt = d & 3;
            m_inc = (d >> 2) & 1;
            if ((d & 8) != 0) m_ovf = 0;
         end
         1: m_ptr = (m_ptr & 'hF00) | d;
         2: m_ptr = (m_ptr & 'h0FF) | ((d & 'hF) << 8);
         3: begin
            if (m_tgt != 3) begin
               if (q.size() < DEPTH) begin
                  e.t = m_tgt; e.a = m_ptr; e.d = d;
                  q.push_back(e);
               end else m_ovf = 1;
            end
            if (m_inc != 0) m_ptr = (m_ptr + m_step) % 4096;
         end
         4: m_step = d;
         default: ;
      endcase
   endtask

   task automatic acc(input int a, input int d, input bit r);
      @(negedge clk);
      addr = 3'(a); data = 8'(d); rw = r; cs_clock = 1'b1;
      repeat (3) @(negedge clk);
      if (!r) model_apply(a, d);
      cs_clock = 1'b0;
      repeat (SYNC + 5) @(negedge clk);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, q.size() != 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_en"}, {t_en, a_en, c_en}, 0);
      chk({tag, "_taddr"}, t_addr, 0);
      chk({tag, "_aaddr"}, a_addr, 0);
      chk({tag, "_caddr"}, c_addr, 0);
      chk({tag, "_data"}, {t_data, a_data, c_data}, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ovf"}, overflow, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_zero("rst_async");
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk_zero("rst_after");
   endtask

   // Every enable must match the oldest expected write
   always @(negedge clk) begin
      ent_t e;
      int   tg;
      if (rst && (t_en || a_en || c_en)) begin
         n_en++;
         chk("onehot", $countones({t_en, a_en, c_en}), 1);
         if (q.size() == 0) begin
            chk("spurious_en", {t_en, a_en, c_en}, 0);
         end else begin
            e  = q.pop_front();
            tg = t_en ? 0 : (a_en ? 1 : 2);
            chk("target", tg, e.t);
            if (t_en) begin
               chk("tile_addr", t_addr, e.a & 'h7FF);
               chk("tile_data", t_data, e.d);
            end else if (a_en) begin
               chk("attr_addr", a_addr, e.a);
               chk("attr_data", a_data, e.d);
            end else begin
               chk("color_addr", c_addr, e.a & 'hF);
               chk("color_data", c_data, e.d);
            end
         end
      end
   end

   initial begin
      int r, first, last, cnt, n0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset_rel");

      acc(2, 'h01, 0); acc(1, 'h23, 0); acc(3, 'hAA, 0);
      acc(3, 'h55, 0);

      acc(0, 'h01, 0); acc(4, 'h10, 0);
      acc(2, 'h0F, 0); acc(1, 'hF8, 0);
      acc(3, 'h11, 0); acc(3, 'h22, 0);

      acc(0, 'h02, 0); acc(2, 'h00, 0); acc(1, 'h13, 0);
      acc(3, 'h5C, 0);

      acc(3, 'h77, 1); acc(1, 'h99, 1); acc(3, 'h66, 0);

`ifdef VRAM_BLANK_WRITE_EN
      vga_blank = 1'b0;
      acc(0, 'h04, 0); acc(4, 'h01, 0);
      acc(2, 'h02, 0); acc(1, 'h40, 0);
      n0 = n_en;
      for (int i = 0; i < DEPTH + 1; i++) acc(3, 'h80 + i, 0);
      chk("stall_en", n_en - n0, 0);
      chk("stall_busy", busy, 1);
      chk("stall_ovf", overflow, 1);
      @(negedge clk);
      vga_blank = 1'b1;
      first = -1; last = -1; cnt = 0;
      for (int c = 0; c < DEPTH + 6; c++) begin
         @(negedge clk);
         if (t_en || a_en || c_en) begin
            if (first < 0) first = c;
            last = c;
            cnt++;
         end
      end
      chk("drain_cnt", cnt, DEPTH);
      chk("drain_consec", last - first + 1, DEPTH);
      acc(0, 'h0C, 0);
      chk("ovf_clr", overflow, 0);
      vga_blank = 1'b0;
      for (int i = 0; i < 3; i++) acc(3, 'hC0 + i, 0);
      chk("q3_busy", busy, 1);
      do_reset();
      vga_blank = 1'b1;
      repeat (10) @(negedge clk);
`else
      acc(0, 'h04, 0); acc(3, 'hE1, 0); acc(3, 'hE2, 0);
      do_reset();
`endif

      for (int i = 0; i < 160; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: acc(0, $urandom_range(0, 255), 0);
            1: acc(1, $urandom_range(0, 255), 0);
            2: acc(2, $urandom_range(0, 255), 0);
            3: acc(4, ($urandom_range(0, 3) == 0) ? 0 :
                      $urandom_range(0, 255), 0);
            8: acc($urandom_range(0, 7), $urandom_range(0, 255), 1);
            9: acc($urandom_range(5, 7), $urandom_range(0, 255), 0);
            default: acc(3, $urandom_range(0, 255), 0);
         endcase
      end
      repeat (10) @(negedge clk);
      chk("drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
